// File: rtl/signext_pipe.sv
// Registered immediate-extension stage with a 2-entry valid/ready buffer.
// Optional pop counter on port ext_count is enabled by defining SIGNEXT_PIPE_CNT_EN.
module signext_pipe #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
`ifdef SIGNEXT_PIPE_CNT_EN
    ,
    output logic [15:0]          ext_count
`endif
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    if (OUT_WIDTH <= IN_WIDTH) begin : g_bad_width
        $error("signext_pipe: OUT_WIDTH must be greater than IN_WIDTH");
    end
    if (DEPTH != 2) begin : g_bad_depth
        $error("signext_pipe: only DEPTH == 2 is supported");
    end

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [OUT_WIDTH-1:0] head_q, head_d;
    logic [OUT_WIDTH-1:0] tail_q, tail_d;
    logic [OUT_WIDTH-1:0] sext;
    logic [OUT_WIDTH-1:0] ext_value;
    logic                 push;
    logic                 pop;

    // Ready and valid depend only on registered occupancy, never on out_ready.
    assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign out_data  = head_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign sext = {{PAD{in_data[IN_WIDTH-1]}}, in_data};

    always_comb begin
        ext_value = '0;
        case (in_mode)
            2'b00:   ext_value = {{PAD{1'b0}}, in_data};
            2'b01:   ext_value = sext;
            2'b10:   ext_value = {sext[OUT_WIDTH-2:0], 1'b0};
            default: ext_value = {in_data, {PAD{1'b0}}};
        endcase
    end

    // ext_value only reaches state when push is true, so X on idle inputs stays out.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = ext_value;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = ext_value;
                end else if (push) begin
                    tail_d  = ext_value;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef SIGNEXT_PIPE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d     = pop ? cnt_q + 16'd1 : cnt_q;
    assign ext_count = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_signext_pipe.sv
// Self-checking bench for signext_pipe (IN_WIDTH=8, OUT_WIDTH=16) with a scoreboard queue.
// Define SIGNEXT_PIPE_CNT_EN at build time to also exercise ext_count.
module tb_signext_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef SIGNEXT_PIPE_CNT_EN
    logic [15:0] ext_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    signext_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SIGNEXT_PIPE_CNT_EN
        ,
        .ext_count (ext_count)
`endif
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // Reference extension for 8 -> 16 bits.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [1:0] m);
        logic signed [15:0] s;
        s = $signed(a);
        case (m)
            2'd0:    return {8'h00, a};
            2'd1:    return s;
            2'd2:    return s <<< 1;
            default: return {a, 8'h00};
        endcase
    endfunction

    // Driver: called at a negedge; drives one cycle and reports what the next edge will do.
    task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] m, input logic r,
                        output logic pu, output logic po, output logic [15:0] obs);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = r;
        #1;
        pu  = in_valid && in_ready;
        po  = out_valid && out_ready;
        obs = out_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  d_tbl[4] = '{8'h80, 8'h80, 8'h81, 8'h12};
        logic [1:0]  m_tbl[4] = '{2'd1, 2'd0, 2'd2, 2'd3};
        logic [15:0] e_tbl[4] = '{16'hFF80, 16'h0080, 16'hFF02, 16'h1200};
        logic pu, po;
        logic [15:0] obs;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) tick(1'b1, d_tbl[i], m_tbl[i], 1'b1, pu, po, obs);
            else       tick(1'b0, 8'h00, 2'd0, 1'b1, pu, po, obs);
            if (i < 4) begin
                checks++;
                if (pu !== 1'b1) begin failures++; $display("FAIL b2b_push[%0d]: accepted=%b want 1", i, pu); end
            end
            if (i == 0 || i == 5) begin
                checks++;
                if (po !== 1'b0) begin failures++; $display("FAIL b2b_idle_pop[%0d]: pop=%b want 0", i, po); end
            end else begin
                checks++;
                if (po !== 1'b1 || obs !== e_tbl[i-1])
                    begin failures++; $display("FAIL b2b_data[%0d]: pop=%b data=%h want pop=1 data=%h", i-1, po, obs, e_tbl[i-1]); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] pend[$] = '{8'h01, 8'h02, 8'h03};
        logic pu, po, v, r;
        logic [7:0]  d;
        logic [15:0] obs, e;
        int npop = 0;
        for (int c = 0; c < 12; c++) begin
            r = (c >= 5);
            v = (pend.size() > 0);
            d = v ? pend[0] : 8'h00;
            tick(v, d, 2'd0, r, pu, po, obs);
            if (c < 2) begin
                checks++;
                if (pu !== 1'b1) begin failures++; $display("FAIL bp_accept[%0d]: accepted=%b want 1", c, pu); end
            end else if (c < 5) begin
                checks++;
                if (pu !== 1'b0 || obs !== 16'h0001)
                    begin failures++; $display("FAIL bp_stall[%0d]: accepted=%b data=%h want 0/0001", c, pu, obs); end
            end
            if (pu) begin
                void'(pend.pop_front());
                exp_q.push_back(model(d, 2'd0));
            end
            if (po) begin
                npop++;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_order: unexpected output %h", obs); end
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin failures++; $display("FAIL bp_order: got %h want %h", obs, e); end
                end
            end
        end
        checks++;
        if (npop != 3 || exp_q.size() != 0)
            begin failures++; $display("FAIL bp_count: pops=%0d left=%0d want 3/0", npop, exp_q.size()); end
    endtask

    task automatic test_one_push_pop;
        logic pu, po;
        logic [15:0] obs;
        tick(1'b1, 8'h05, 2'd0, 1'b0, pu, po, obs);
        tick(1'b1, 8'h7F, 2'd1, 1'b1, pu, po, obs);
        checks++;
        if (pu !== 1'b1 || po !== 1'b1 || obs !== 16'h0005)
            begin failures++; $display("FAIL one_pushpop: push=%b pop=%b data=%h want 1/1/0005", pu, po, obs); end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 16'h007F)
            begin failures++; $display("FAIL one_hold: valid=%b ready=%b data=%h want 1/1/007F", out_valid, in_ready, out_data); end
        tick(1'b0, 8'h00, 2'd0, 1'b1, pu, po, obs);
        checks++;
        if (po !== 1'b1 || obs !== 16'h007F) begin failures++; $display("FAIL one_drain: pop=%b data=%h want 1/007F", po, obs); end
        tick(1'b0, 8'h00, 2'd0, 1'b0, pu, po, obs);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL one_empty: valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        logic pu, po;
        logic [15:0] obs;
        tick(1'b1, 8'h11, 2'd0, 1'b0, pu, po, obs);
        tick(1'b1, 8'h22, 2'd0, 1'b0, pu, po, obs);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_full: in_ready=%b want 0", in_ready); end
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h33; in_mode = 2'd1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000)
            begin failures++; $display("FAIL rmid_state: valid=%b ready=%b data=%h want 0/1/0000", out_valid, in_ready, out_data); end
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h00, 2'd0, 1'b1, pu, po, obs);
            checks++;
            if (po !== 1'b0) begin failures++; $display("FAIL rmid_stale[%0d]: output %h after reset", i, obs); end
        end
        tick(1'b1, 8'h44, 2'd1, 1'b1, pu, po, obs);
        tick(1'b0, 8'h00, 2'd0, 1'b1, pu, po, obs);
        checks++;
        if (po !== 1'b1 || obs !== 16'h0044) begin failures++; $display("FAIL rmid_fresh: pop=%b data=%h want 1/0044", po, obs); end
    endtask

    task automatic test_random;
        logic pu, po, v, r, ov, prev_stall;
        logic [7:0]  d;
        logic [1:0]  m;
        logic [15:0] obs, prev_obs, e;
        prev_stall = 1'b0;
        prev_obs   = 16'h0000;
        for (int c = 0; c < 320; c++) begin
            v = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
            d = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            r = (c < 300) ? ($urandom_range(0, 2) != 0) : 1'b1;
            ov = out_valid;
            tick(v, d, m, r, pu, po, obs);
            if (prev_stall) begin
                checks++;
                if (obs !== prev_obs) begin failures++; $display("FAIL rnd_stable[%0d]: got %h want %h", c, obs, prev_obs); end
            end
            if (pu) exp_q.push_back(model(d, m));
            if (po) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_order[%0d]: unexpected output %h", c, obs); end
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin failures++; $display("FAIL rnd_order[%0d]: got %h want %h", c, obs, e); end
                end
            end
            prev_stall = ov && !r;
            prev_obs   = obs;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL rnd_drain: left=%0d valid=%b want 0/0", exp_q.size(), out_valid); end
    endtask

`ifdef SIGNEXT_PIPE_CNT_EN
    task automatic test_count;
        logic pu, po;
        logic [15:0] obs;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ext_count !== 16'd0) begin failures++; $display("FAIL cnt_reset: got %0d want 0", ext_count); end
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(i), 2'd0, 1'b1, pu, po, obs);
        tick(1'b0, 8'h00, 2'd0, 1'b1, pu, po, obs);
        checks++;
        if (ext_count !== 16'd5) begin failures++; $display("FAIL cnt_five: got %0d want 5", ext_count); end
        for (int i = 0; i < 65531; i++) tick(1'b1, 8'h00, 2'd0, 1'b1, pu, po, obs);
        tick(1'b0, 8'h00, 2'd0, 1'b1, pu, po, obs);
        checks++;
        if (ext_count !== 16'd0) begin failures++; $display("FAIL cnt_wrap: got %0d want 0", ext_count); end
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0; out_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_one_push_pop;
        test_reset_mid;
        test_random;
`ifdef SIGNEXT_PIPE_CNT_EN
        test_count;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signext_pipe.md
Name: signext_pipe

Overview:
- Parametrised, registered immediate-extension stage for the 16-bit datapath.
- Successor to the fixed 8-to-16 combinational sign extender. Adds configurable widths, four extension modes, and a 2-entry valid/ready buffer.
- Sits between instruction decode and the ALU operand mux, so backpressure from the execute stage stalls decode without losing immediates.

Parameters:
- IN_WIDTH, 8, width of the raw immediate field.
- OUT_WIDTH, 16, width of the extended result. Must satisfy OUT_WIDTH > IN_WIDTH; otherwise `$error` at elaboration.
- DEPTH, 2, buffer entries. Only 2 is supported; any other value raises `$error`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents in_data/in_mode.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  IN_WIDTH  raw immediate.
- in_mode  input  2  extension mode: 00 zero, 01 sign, 10 sign-shift, 11 upper.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  OUT_WIDTH  extended result.

Behaviour:
- One clock. Reset is synchronous and active-high; clk and reset are the only clock/reset ports.
- Extension is computed combinationally at push time; the result is stored in the buffer.
  - Mode 00: zeros in the upper OUT_WIDTH-IN_WIDTH bits, then a.
  - Mode 01: replicate a[IN_WIDTH-1] into the upper bits, then a.
  - Mode 10: sign-extend as mode 01, then shift left 1, keeping the low OUT_WIDTH bits (MSB dropped, LSB=0).
  - Mode 11: a placed in the top IN_WIDTH bits of the result, remaining low bits 0 (load-upper).
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready is registered-state based only: high iff occupancy < 2. No combinational path from out_ready.
  - out_data and out_valid are driven from the head entry register.
  - While out_valid && !out_ready, out_data must stay stable.
- Occupancy FSM:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE, with head replaced by the new entry.
  - TWO: pop -> ONE, tail moves to head. in_ready=0, so no push.
  - Idle (no push/pop) -> hold state in all cases.
- Latency: an entry pushed at edge N has out_valid=1 in cycle N+1 when the buffer was EMPTY, or when in ONE with a simultaneous pop.
- Throughput: 1 entry/cycle with out_ready held high.
- Order: strict FIFO.
- Reset values: state EMPTY, in_ready=1 is allowed combinationally from state, out_valid=0, out_data=0, both entry registers 0.
- Reset mid-operation: all buffered entries are discarded. A push presented in the reset cycle is ignored.
- in_mode/in_data are don't-care when in_valid=0. X on them must not propagate into state.

Optional Feature:
- Macro: SIGNEXT_PIPE_CNT_EN.
- When defined, adds an output port `ext_count [15:0]`.
  - Counts pops.
  - Resets to 0 on reset.
  - Wraps 0xFFFF -> 0x0000.
  - Increments exactly once per pop cycle.
- When not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, out_data=0x0000.
- IN=8/OUT=16, out_ready=1. Push (0x80, 01), (0x80, 00), (0x81, 10), (0x12, 11) back-to-back -> out_data 0xFF80, 0x0080, 0xFF02, 0x1200 in consecutive cycles, each 1 cycle after push.
- out_ready=0, push 0x01, 0x02, 0x03 -> 0x01 and 0x02 accepted; in_ready=0 after the second push; 0x03 held upstream. out_data=0x0001 stable. Raise out_ready -> outputs 0x0001, 0x0002, 0x0003 in order, none lost or duplicated.
- Buffer at ONE, simultaneous push 0x7F (01) and pop -> stays ONE; next out_data=0x007F.
- Buffer at TWO, assert reset for 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1; no stale data emerges afterwards.
- With SIGNEXT_PIPE_CNT_EN, complete 5 pops -> ext_count=5. Preload via 65536 pops -> ext_count wraps to 0.
